// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state and mode encodings for the PISO serializer
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  localparam logic MODE_MSB_FIRST = 1'b0;
  localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with valid/ready load
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int SR_W  = FRAME_LEN - 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  piso_state_t      state;
  logic             dir_q;
  logic [SR_W-1:0]  shreg;
  logic [CNT_W-1:0] cnt;

  logic [FRAME_LEN-1:0] frame;
  logic                 first_bit;
  logic [SR_W-1:0]      rest;
  logic                 last;

  // Frame is arranged so the bit at the output end goes first in either direction.
  always_comb begin
    frame     = '0;
`ifdef PISO_PARITY_EN
    frame     = (mode == MODE_LSB_FIRST) ? {^din, din} : {din, ^din};
`else
    frame     = din;
`endif
    first_bit = (mode == MODE_LSB_FIRST) ? frame[0] : frame[FRAME_LEN-1];
    rest      = (mode == MODE_LSB_FIRST) ? frame[FRAME_LEN-1:1] : frame[SR_W-1:0];
  end

  assign last       = (cnt == CNT_W'(FRAME_LEN - 1));
  assign load_ready = (state == IDLE) || ((state == SHIFT) && last);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dir_q      <= MODE_MSB_FIRST;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (load_ready && load_valid) begin
          // Covers both a load from IDLE and a gapless reload on the last bit.
          state      <= SHIFT;
          dir_q      <= mode;
          sout       <= first_bit;
          shreg      <= rest;
          sout_valid <= 1'b1;
          cnt        <= '0;
          done       <= (state == SHIFT);
        end else if (state == SHIFT) begin
          if (last) begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            cnt        <= '0;
            done       <= 1'b1;
          end else begin
            if (dir_q == MODE_LSB_FIRST) begin
              sout  <= shreg[0];
              shreg <= shreg >> 1;
            end else begin
              sout  <= shreg[SR_W-1];
              shreg <= shreg << 1;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
